// File: rtl/fifo_sync_ext.sv
// rtl/fifo_sync_ext.sv - synchronous FIFO with occupancy count, programmable level flags,
// sticky error flags and selectable first-word-fall-through read.
module fifo_sync_ext #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cs,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          clr_err,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "fifo_sync_ext: FIFO_DEPTH must be a power of two and at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_bad_af
      $fatal(1, "fifo_sync_ext: AF_LEVEL out of range 1..FIFO_DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_bad_ae
      $fatal(1, "fifo_sync_ext: AE_LEVEL out of range 0..FIFO_DEPTH-1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  empty_w, full_w;
  logic                  rd_acc, wr_acc;
  logic                  ovf_set, udf_set;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);

  // A full FIFO still takes a write when a read frees the head slot in the same cycle.
  assign rd_acc  = cs & rd_en & ~empty_w;
  assign wr_acc  = cs & wr_en & (~full_w | rd_acc);
  assign ovf_set = cs & wr_en & ~wr_acc;
  assign udf_set = cs & rd_en & empty_w;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
    // A set event in the same cycle as clr_err takes priority.
    if (ovf_set)      overflow_d = 1'b1;
    else if (clr_err) overflow_d = 1'b0;
    if (udf_set)      underflow_d = 1'b1;
    else if (clr_err) underflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      assign data_out = mem_q[rd_ptr_q];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         data_q <= '0;
        else if (rd_acc) data_q <= mem_q[rd_ptr_q];
      end
      assign data_out = data_q;
    end
  endgenerate

  assign empty        = empty_w;
  assign full         = full_w;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
